// File: rtl/lif_pkg.sv
//------------------------------------------------------------------------------
// lif_pkg : shared LIF defaults and saturating-add helper
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package lif_pkg;

   localparam int unsigned DEF_WIDTH      = 8;
   localparam int unsigned DEF_THRESHOLD  = 200;
   localparam int unsigned DEF_LEAK_SHIFT = 1;
   localparam int unsigned DEF_REFRAC     = 2;

   // Operands are zero-extended to 32 bits; result clips to 2^width-1.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned width);
      logic [32:0] sum;
      logic [32:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = (33'd1 << width) - 33'd1;
      return (sum > lim) ? lim[31:0] : sum[31:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/lif_mux_array_if.sv
//------------------------------------------------------------------------------
// lif_mux_array_if : current-write, monitor and spike-report bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface lif_mux_array_if #(
   parameter int unsigned N_NEURONS = 4,
   parameter int unsigned WIDTH     = 8
);
   localparam int unsigned ADDR_W = $clog2(N_NEURONS);

   logic                 ena;
   logic                 cur_we;
   logic [ADDR_W-1:0]    cur_addr;
   logic [WIDTH-1:0]     cur_data;
   logic [ADDR_W-1:0]    mon_sel;
   logic [WIDTH-1:0]     mon_state;
   logic [N_NEURONS-1:0] spike_vec;
   logic                 spike_pulse;
   logic [ADDR_W-1:0]    spike_idx;
   logic                 frame_done;

   modport master (
      output ena, cur_we, cur_addr, cur_data, mon_sel,
      input  mon_state, spike_vec, spike_pulse, spike_idx, frame_done
   );

   modport slave (
      input  ena, cur_we, cur_addr, cur_data, mon_sel,
      output mon_state, spike_vec, spike_pulse, spike_idx, frame_done
   );

endinterface

`default_nettype wire

// File: rtl/lif_update.sv
//------------------------------------------------------------------------------
// lif_update : combinational single-neuron leak/integrate/fire step
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lif_update
   import lif_pkg::*;
#(
   parameter int unsigned WIDTH      = DEF_WIDTH,
   parameter int unsigned LEAK_SHIFT = DEF_LEAK_SHIFT,
   parameter int unsigned THRESHOLD  = DEF_THRESHOLD,
   parameter int unsigned REFRAC     = DEF_REFRAC,
   parameter int unsigned REF_W      = 2
) (
   input  logic [WIDTH-1:0] state,
   input  logic [WIDTH-1:0] current,
   input  logic [REF_W-1:0] refrac,
   output logic [WIDTH-1:0] next_state,
   output logic [REF_W-1:0] next_refrac,
   output logic             spike
);

   localparam logic [WIDTH:0] c_thresh = (WIDTH+1)'(THRESHOLD);

   logic [WIDTH-1:0] w_leaked;
   logic [WIDTH-1:0] w_sum;

   assign w_leaked = state - (state >> LEAK_SHIFT);
   assign w_sum    = WIDTH'(sat_add(32'(w_leaked), 32'(current), WIDTH));

   always_comb begin
      next_state  = state;
      next_refrac = refrac;
      spike       = 1'b0;
      if (refrac != '0) begin
         next_state  = '0;
         next_refrac = refrac - REF_W'(1);
      end else if ({1'b0, w_sum} >= c_thresh) begin
         spike       = 1'b1;
         next_state  = '0;
         next_refrac = REF_W'(REFRAC);
      end else begin
         next_state  = w_sum;
      end
   end

endmodule

`default_nettype wire

// File: rtl/lif_mux_array.sv
//------------------------------------------------------------------------------
// lif_mux_array : N LIF neurons sharing one update datapath, round-robin slots
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lif_mux_array
   import lif_pkg::*;
#(
   parameter int unsigned N_NEURONS  = 4,
   parameter int unsigned WIDTH      = DEF_WIDTH,
   parameter int unsigned LEAK_SHIFT = DEF_LEAK_SHIFT,
   parameter int unsigned THRESHOLD  = DEF_THRESHOLD,
   parameter int unsigned REFRAC     = DEF_REFRAC
) (
   input  logic           clk,
   input  logic           rst_n,
   lif_mux_array_if.slave bus
);

   localparam int unsigned ADDR_W = $clog2(N_NEURONS);
   localparam int unsigned REF_W  = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
   localparam logic [ADDR_W:0]   c_n    = (ADDR_W+1)'(N_NEURONS);
   localparam logic [ADDR_W-1:0] c_last = ADDR_W'(N_NEURONS - 1);

   logic [WIDTH-1:0]     r_state [N_NEURONS];
   logic [WIDTH-1:0]     r_cur   [N_NEURONS];
   logic [REF_W-1:0]     r_ref   [N_NEURONS];
   logic [ADDR_W-1:0]    r_idx;
   logic [N_NEURONS-1:0] r_vec;
   logic                 r_pulse;
   logic [ADDR_W-1:0]    r_spike_idx;
   logic                 r_done;
   logic [WIDTH-1:0]     r_mon;

   logic [WIDTH-1:0]     w_next_state;
   logic [REF_W-1:0]     w_next_ref;
   logic                 w_spike;
   logic [WIDTH-1:0]     w_mon;

   lif_update #(
      .WIDTH      (WIDTH),
      .LEAK_SHIFT (LEAK_SHIFT),
      .THRESHOLD  (THRESHOLD),
      .REFRAC     (REFRAC),
      .REF_W      (REF_W)
   ) u_update (
      .state       (r_state[r_idx]),
      .current     (r_cur[r_idx]),
      .refrac      (r_ref[r_idx]),
      .next_state  (w_next_state),
      .next_refrac (w_next_ref),
      .spike       (w_spike)
   );

   assign w_mon = ({1'b0, bus.mon_sel} < c_n) ? r_state[bus.mon_sel] : '0;

   // The datapath reads r_cur before this edge, so a same-cycle write lands next visit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_NEURONS; i++) begin
            r_state[i] <= '0;
            r_cur[i]   <= '0;
            r_ref[i]   <= '0;
         end
         r_vec <= '0;
      end else begin
         for (int i = 0; i < N_NEURONS; i++) begin
            if (bus.cur_we && (bus.cur_addr == ADDR_W'(i))) begin
               r_cur[i] <= bus.cur_data;
            end
            if (bus.ena && (r_idx == ADDR_W'(i))) begin
               r_state[i] <= w_next_state;
               r_ref[i]   <= w_next_ref;
               r_vec[i]   <= w_spike;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx       <= '0;
         r_pulse     <= 1'b0;
         r_spike_idx <= '0;
         r_done      <= 1'b0;
         r_mon       <= '0;
      end else begin
         r_mon   <= w_mon;
         r_pulse <= bus.ena & w_spike;
         r_done  <= bus.ena & (r_idx == c_last);
         if (bus.ena) begin
            r_spike_idx <= r_idx;
            r_idx       <= (r_idx == c_last) ? '0 : r_idx + ADDR_W'(1);
         end
      end
   end

   assign bus.mon_state   = r_mon;
   assign bus.spike_vec   = r_vec;
   assign bus.spike_pulse = r_pulse;
   assign bus.spike_idx   = r_spike_idx;
   assign bus.frame_done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_lif_mux_array.sv
//------------------------------------------------------------------------------
// tb_lif_mux_array : scoreboard bench for lif_mux_array (two configurations)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_lif_mux_array;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic sel   = 1'b0;
   logic ena_q = 1'b0;

   always #5 clk = ~clk;

   lif_mux_array_if #(.N_NEURONS(5), .WIDTH(8)) bus_a ();
   lif_mux_array_if #(.N_NEURONS(4), .WIDTH(8)) bus_b ();

   lif_mux_array #(.N_NEURONS(5)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   lif_mux_array #(.N_NEURONS(4), .THRESHOLD(255)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   typedef struct packed {
      logic [2:0] idx;
      logic       pulse;
      logic       fd;
      logic       chk;
      logic [7:0] st;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [7:0] st0 [8] = '{8'd100, 8'd150, 8'd175, 8'd188, 8'd194, 8'd197, 8'd199, 8'd0};

   logic [2:0] m_idx;
   logic [4:0] m_vec;
   logic       m_pulse;
   logic       m_fd;
   logic [7:0] m_state;

   always_comb begin
      if (sel) begin
         m_idx   = {1'b0, bus_b.spike_idx};
         m_vec   = {1'b0, bus_b.spike_vec};
         m_pulse = bus_b.spike_pulse;
         m_fd    = bus_b.frame_done;
         m_state = bus_b.mon_state;
      end else begin
         m_idx   = bus_a.spike_idx;
         m_vec   = bus_a.spike_vec;
         m_pulse = bus_a.spike_pulse;
         m_fd    = bus_a.frame_done;
         m_state = bus_a.mon_state;
      end
   end

   always @(posedge clk) ena_q <= rst_n && (sel ? bus_b.ena : bus_a.ena);

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expect_slot(input int slot, input int nn, input logic pulse,
                              input logic chk, input logic [7:0] st);
      exp_t e;
      e.idx   = 3'(slot);
      e.pulse = pulse;
      e.fd    = (slot == nn - 1);
      e.chk   = chk;
      e.st    = st;
      q.push_back(e);
   endtask

   // Monitor: pops one expectation per enabled edge; tracks what must hold otherwise.
   logic [4:0] exp_vec    = '0;
   logic [2:0] last_idx   = '0;
   logic [7:0] last_state = '0;
   logic       pend       = 1'b0;
   logic [7:0] pend_val   = '0;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         check("rst_pulse", m_pulse, 0);
         check("rst_done", m_fd, 0);
         check("rst_idx", m_idx, 0);
         check("rst_vec", m_vec, 0);
         check("rst_mon", m_state, 0);
         exp_vec = '0; last_idx = '0; last_state = '0; pend = 1'b0;
      end else begin
         if (pend) begin
            check("mon_state", m_state, pend_val);
            last_state = pend_val;
            pend = 1'b0;
         end
         if (ena_q) begin
            if (q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL scoreboard: output with no expectation queued (t=%0t)", $time);
            end else begin
               e = q.pop_front();
               check("spike_idx", m_idx, e.idx);
               check("spike_pulse", m_pulse, e.pulse);
               check("frame_done", m_fd, e.fd);
               exp_vec[e.idx] = e.pulse;
               last_idx = e.idx;
               if (e.chk) begin pend = 1'b1; pend_val = e.st; end
            end
         end else begin
            check("idle_pulse", m_pulse, 0);
            check("idle_done", m_fd, 0);
            check("idle_idx", m_idx, last_idx);
            check("idle_mon", m_state, last_state);
         end
         check("spike_vec", m_vec, exp_vec);
      end
   end

   initial begin
      logic       p;
      logic [7:0] st;
      bus_a.ena = 1'b1; bus_a.cur_we = 1'b1; bus_a.cur_addr = 3'd1;
      bus_a.cur_data = 8'd77; bus_a.mon_sel = 3'd1;
      bus_b.ena = 1'b0; bus_b.cur_we = 1'b0; bus_b.cur_addr = '0;
      bus_b.cur_data = '0; bus_b.mon_sel = 2'd2;

      // Reset with live inputs, then a short run aborted by a mid-frame reset.
      #3 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      bus_a.ena = 1'b0; bus_a.cur_we = 1'b0; bus_a.mon_sel = 3'd0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus_a.ena = 1'b1;
      for (int s = 0; s < 3; s++) begin
         expect_slot(s, 5, 1'b0, (s == 0), 8'd0);
         @(posedge clk); #1;
      end
      @(negedge clk); #1;
      bus_a.ena = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Currents written while disabled.
      bus_a.cur_we = 1'b1; bus_a.cur_addr = 3'd0; bus_a.cur_data = 8'd100;
      @(posedge clk); #1;
      bus_a.cur_addr = 3'd1; bus_a.cur_data = 8'd250;
      @(posedge clk); #1;
      bus_a.cur_we = 1'b0;
      bus_a.ena = 1'b1;

      for (int f = 0; f < 8; f++) begin
         for (int s = 0; s < 5; s++) begin
            p = 1'b0; st = 8'd0;
            case (s)
               0: begin st = st0[f]; p = (f == 7); end
               1: p = ((f % 3) == 0);
               3: p = (f == 2) || (f == 5);
               default: ;
            endcase
            if (f == 0 && s == 1) begin
               bus_a.cur_we = 1'b1; bus_a.cur_addr = 3'd5; bus_a.cur_data = 8'd10;
            end
            if (f == 1 && s == 3) begin
               bus_a.cur_we = 1'b1; bus_a.cur_addr = 3'd3; bus_a.cur_data = 8'd220;
            end
            expect_slot(s, 5, p, (s == 0), st);
            @(posedge clk); #1;
            bus_a.cur_we = 1'b0;
            if (f == 5 && s == 2) begin
               bus_a.ena = 1'b0;
               repeat (10) @(posedge clk);
               #1 bus_a.ena = 1'b1;
            end
         end
      end
      bus_a.ena = 1'b0;

      // Saturation at THRESHOLD=255 on the second configuration.
      @(negedge clk); #1;
      rst_n = 1'b0;
      sel   = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      bus_b.cur_we = 1'b1; bus_b.cur_addr = 2'd2; bus_b.cur_data = 8'd200;
      @(posedge clk); #1;
      bus_b.cur_we = 1'b0;
      bus_b.ena = 1'b1;
      for (int f = 0; f < 2; f++) begin
         for (int s = 0; s < 4; s++) begin
            expect_slot(s, 4, (f == 1 && s == 2), (s == 2),
                        (f == 0 && s == 2) ? 8'd200 : 8'd0);
            @(posedge clk); #1;
         end
      end
      bus_b.ena = 1'b0;
      repeat (2) @(negedge clk);
      check("queue_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
